// File: rtl/merger_tree_p1_l64_if.sv
// Signal bundle between the merge tree, its leaf FIFOs (show-ahead) and the output FIFO.
interface merger_tree_p1_l64_if #(
  parameter int LEAF_CNT   = 128,
  parameter int DATA_WIDTH = 32
);
  logic [LEAF_CNT*DATA_WIDTH-1:0] i_fifo;
  logic [LEAF_CNT-1:0]            i_fifo_empty;
  logic                           i_fifo_out_ready;
  logic [LEAF_CNT-1:0]            o_fifo_read;
  logic                           o_out_fifo_write;
  logic [DATA_WIDTH-1:0]          o_data;

  // Handshake: leaf k's head word is valid while !i_fifo_empty[k] and is consumed at the posedge
  // where o_fifo_read[k]=1 (never raised while empty). o_out_fifo_write already includes
  // i_fifo_out_ready, so a high o_out_fifo_write means o_data transfers at that posedge.
  modport master (
    output i_fifo, i_fifo_empty, i_fifo_out_ready,
    input  o_fifo_read, o_out_fifo_write, o_data
  );
  modport slave (
    input  i_fifo, i_fifo_empty, i_fifo_out_ready,
    output o_fifo_read, o_out_fifo_write, o_data
  );
endinterface

// File: rtl/merger_tree_p1_l64.sv
// Pipelined binary merge tree: 2*L descending, 0-terminated leaf streams merged into one stream.
// Nodes are heap-indexed (root 1, children 2n/2n+1); slots >= LEAF_CNT are the leaf heads.
module merger_tree_p1_l64 #(
  parameter int L          = 64,
  parameter int DATA_WIDTH = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  merger_tree_p1_l64_if.slave bus
);
  localparam int LEAF_CNT = 2 * L;
  localparam int NODES    = LEAF_CNT - 1;
  localparam int SLOTS    = 2 * LEAF_CNT - 1;

  logic [1:0]            cnt_q  [1:NODES];
  logic [1:0]            cnt_d  [1:NODES];
  logic [DATA_WIDTH-1:0] head_q [1:NODES];
  logic [DATA_WIDTH-1:0] head_d [1:NODES];
  logic [DATA_WIDTH-1:0] tail_q [1:NODES];
  logic [DATA_WIDTH-1:0] tail_d [1:NODES];
  logic [DATA_WIDTH-1:0] last_q;
  logic [DATA_WIDTH-1:0] last_d;

  logic                  slot_vld [1:SLOTS];
  logic [DATA_WIDTH-1:0] slot_dat [1:SLOTS];
  logic                  slot_pop [1:SLOTS];
  logic                  fire     [1:NODES];
  logic [DATA_WIDTH-1:0] push_dat [1:NODES];
  logic [LEAF_CNT-1:0]   rd_vec;
  logic                  out_wr;
  logic [DATA_WIDTH-1:0] out_dat;

  always_comb begin
    for (int n = 1; n <= NODES; n++) begin
      slot_vld[n] = (cnt_q[n] != 2'd0);
      slot_dat[n] = head_q[n];
      slot_pop[n] = 1'b0;
    end
    for (int k = 0; k < LEAF_CNT; k++) begin
      slot_vld[LEAF_CNT+k] = !bus.i_fifo_empty[k];
      slot_dat[LEAF_CNT+k] = bus.i_fifo[k*DATA_WIDTH +: DATA_WIDTH];
      slot_pop[LEAF_CNT+k] = 1'b0;
    end

    out_wr      = i_rst_n && slot_vld[1] && bus.i_fifo_out_ready;
    out_dat     = out_wr ? slot_dat[1] : last_q;
    last_d      = out_dat;
    slot_pop[1] = out_wr;

    // Ascending n: a node's own pop is decided by its parent before the node itself is evaluated.
    for (int n = 1; n <= NODES; n++) begin
      logic [DATA_WIDTH-1:0] a_dat;
      logic [DATA_WIDTH-1:0] b_dat;
      logic                  a_win;
      logic                  both_zero;
      a_dat     = slot_dat[2*n];
      b_dat     = slot_dat[2*n+1];
      a_win     = (a_dat >= b_dat);
      both_zero = (a_dat == '0) && (b_dat == '0);
      fire[n]   = i_rst_n && slot_vld[2*n] && slot_vld[2*n+1]
                  && ((cnt_q[n] != 2'd2) || slot_pop[n]);
      push_dat[n]       = a_win ? a_dat : b_dat;
      slot_pop[2*n]     = fire[n] && a_win;
      slot_pop[2*n+1]   = fire[n] && (!a_win || both_zero);

      cnt_d[n]  = cnt_q[n];
      head_d[n] = head_q[n];
      tail_d[n] = tail_q[n];
      case ({fire[n], slot_pop[n]})
        2'b01: begin
          head_d[n] = tail_q[n];
          cnt_d[n]  = cnt_q[n] - 2'd1;
        end
        2'b10: begin
          if (cnt_q[n] == 2'd0) head_d[n] = push_dat[n];
          else                  tail_d[n] = push_dat[n];
          cnt_d[n] = cnt_q[n] + 2'd1;
        end
        2'b11: begin
          if (cnt_q[n] == 2'd1) begin
            head_d[n] = push_dat[n];
          end else begin
            head_d[n] = tail_q[n];
            tail_d[n] = push_dat[n];
          end
        end
        default: ;
      endcase
    end

    rd_vec = '0;
    for (int k = 0; k < LEAF_CNT; k++) rd_vec[k] = slot_pop[LEAF_CNT+k];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int n = 1; n <= NODES; n++) begin
        cnt_q[n]  <= 2'd0;
        head_q[n] <= '0;
        tail_q[n] <= '0;
      end
      last_q <= '0;
    end else begin
      for (int n = 1; n <= NODES; n++) begin
        cnt_q[n]  <= cnt_d[n];
        head_q[n] <= head_d[n];
        tail_q[n] <= tail_d[n];
      end
      last_q <= last_d;
    end
  end

  assign bus.o_fifo_read      = rd_vec;
  assign bus.o_out_fifo_write = out_wr;
  assign bus.o_data           = out_dat;
endmodule

// File: tb/tb_merger_tree_p1_l64.sv
// Bench for merger_tree_p1_l64: leaf FIFO model, expected-queue scoreboard on the output stream.
module tb_merger_tree_p1_l64;
  localparam int L        = 64;
  localparam int LEAF_CNT = 2 * L;
  localparam int DW       = 32;
  localparam int DEPTH    = 160;
  localparam int BIG_N    = 128;
  localparam int BIG_Z    = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  merger_tree_p1_l64_if #(.LEAF_CNT(LEAF_CNT), .DATA_WIDTH(DW)) bus ();
  merger_tree_p1_l64 #(.L(L), .DATA_WIDTH(DW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  logic [DW-1:0]       leaf_mem [LEAF_CNT][DEPTH];
  int                  leaf_len [LEAF_CNT];
  int                  leaf_ptr [LEAF_CNT];
  logic [DW-1:0]       big_mem  [LEAF_CNT][BIG_N];
  logic [DW-1:0]       big_exp[$];
  logic [DW-1:0]       exp_q[$];
  int                  tie_log[$];
  logic [LEAF_CNT-1:0] rd_s;
  logic                wr_s;
  logic [DW-1:0]       data_s;
  logic [DW-1:0]       last_data;
  int tests, fails, cyc, ready_mode, mask_leaf, mask_from, mask_to;
  int rd_empty_viol, spurious, first_wr_cyc, load_cyc;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // driver
  task automatic drive_inputs();
    for (int k = 0; k < LEAF_CNT; k++) begin
      logic emp;
      emp = (leaf_ptr[k] >= leaf_len[k]) ||
            (k == mask_leaf && cyc >= mask_from && cyc < mask_to);
      bus.i_fifo_empty[k]    = emp;
      bus.i_fifo[k*DW +: DW] = emp ? 32'hFFFF_FFFF : leaf_mem[k][leaf_ptr[k]];
    end
  endtask

  task automatic clear_leaves();
    for (int k = 0; k < LEAF_CNT; k++) begin
      leaf_len[k] = 0;
      leaf_ptr[k] = 0;
    end
    rd_s = '0;
    drive_inputs();
  endtask

  // One cycle: apply pops seen last cycle, drive new inputs, then sample and score at negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) last_data = '0;
    for (int k = 0; k < LEAF_CNT; k++) begin
      if (rd_s[k] && leaf_ptr[k] < leaf_len[k]) begin
        if (k < 2 && leaf_mem[k][leaf_ptr[k]] != '0) tie_log.push_back(k);
        leaf_ptr[k]++;
      end
    end
    if (ready_mode == 1) bus.i_fifo_out_ready = (cyc % 2 == 1);
    else                 bus.i_fifo_out_ready = 1'b1;
    drive_inputs();

    @(negedge clk);
    rd_s   = bus.o_fifo_read;
    wr_s   = bus.o_out_fifo_write;
    data_s = bus.o_data;
    if ((rd_s & bus.i_fifo_empty) != '0) rd_empty_viol++;
    if (!rst_n) begin
      chk("rst_read", 64'($countones(rd_s)), 64'd0);
      chk("rst_write", 64'(wr_s), 64'd0);
    end
    if (wr_s) begin
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (exp_q.size() == 0) spurious++;
      else chk("data", 64'(data_s), 64'(exp_q.pop_front()));
      last_data = data_s;
    end else begin
      chk("hold", 64'(data_s), 64'(last_data));
    end
  endtask

  task automatic run_until_drained(input string tag, input int budget);
    int n;
    int left;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
    repeat (10) tick();
    left = 0;
    for (int k = 0; k < LEAF_CNT; k++) left += leaf_len[k] - leaf_ptr[k];
    chk({tag, "_leaves_left"}, 64'(left), 64'd0);
    chk({tag, "_spurious"}, 64'(spurious), 64'd0);
  endtask

  task automatic gen_big();
    logic [DW-1:0] all_q[$];
    logic [DW-1:0] tmp[$];
    for (int k = 0; k < LEAF_CNT; k++) begin
      tmp.delete();
      for (int j = 0; j < BIG_N; j++) tmp.push_back(DW'($urandom_range(100000, 1)));
      tmp.rsort();
      for (int j = 0; j < BIG_N; j++) begin
        big_mem[k][j] = tmp[j];
        all_q.push_back(tmp[j]);
      end
    end
    all_q.rsort();
    big_exp = all_q;
  endtask

  task automatic load_big();
    for (int k = 0; k < LEAF_CNT; k++) begin
      for (int j = 0; j < BIG_N; j++) leaf_mem[k][j] = big_mem[k][j];
      for (int j = 0; j < BIG_Z; j++) leaf_mem[k][BIG_N+j] = '0;
      leaf_len[k] = BIG_N + BIG_Z;
      leaf_ptr[k] = 0;
    end
    foreach (big_exp[i]) exp_q.push_back(big_exp[i]);
    for (int j = 0; j < BIG_Z; j++) exp_q.push_back('0);
  endtask

  task automatic run_tie(input string tag);
    int tie_exp[3];
    tie_exp = '{0, 0, 1};
    for (int k = 0; k < LEAF_CNT; k++) begin
      leaf_mem[k][0] = '0;
      leaf_len[k]    = 1;
      leaf_ptr[k]    = 0;
    end
    leaf_mem[0][0] = 32'd5; leaf_mem[0][1] = 32'd5; leaf_mem[0][2] = '0; leaf_len[0] = 3;
    leaf_mem[1][0] = 32'd5; leaf_mem[1][1] = '0;                         leaf_len[1] = 2;
    tie_log.delete();
    exp_q.push_back(32'd5); exp_q.push_back(32'd5); exp_q.push_back(32'd5); exp_q.push_back('0);
    run_until_drained(tag, 200);
    chk({tag, "_pops"}, 64'(tie_log.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk({tag, "_pop_order"}, 64'((i < tie_log.size()) ? tie_log[i] : 99), 64'(tie_exp[i]));
  endtask

  initial begin
    logic [DW-1:0] tmp[$];
    logic [DW-1:0] all_q[$];
    tests = 0; fails = 0; cyc = 0; ready_mode = 0;
    mask_leaf = -1; mask_from = 0; mask_to = 0;
    rd_empty_viol = 0; spurious = 0; first_wr_cyc = -1; load_cyc = 0;
    rd_s = '0; last_data = '0;
    rst_n = 1'b0;
    bus.i_fifo_out_ready = 1'b1;

    // Case 1: reset held with every leaf non-empty
    for (int k = 0; k < LEAF_CNT; k++) begin
      leaf_mem[k][0] = 32'd7;
      leaf_len[k]    = 1;
      leaf_ptr[k]    = 0;
    end
    drive_inputs();
    repeat (3) tick();
    clear_leaves();
    rst_n = 1'b1;
    tick();

    // Case 2: full batch, ready high, plus first-write latency
    gen_big();
    load_big();
    first_wr_cyc = -1;
    load_cyc     = cyc + 1;
    run_until_drained("big", 40000);
    chk("latency", 64'(first_wr_cyc - load_cyc), 64'd7);

    // Case 3: tie ordering
    run_tie("tie");

    // Case 4: same batch with ready toggling
    ready_mode = 1;
    load_big();
    run_until_drained("big_toggle", 40000);
    ready_mode = 0;

    // Case 5: leaf 3 starved for 50 cycles mid-stream
    for (int k = 0; k < LEAF_CNT; k++) begin
      tmp.delete();
      for (int j = 0; j < 16; j++) tmp.push_back(DW'($urandom_range(5000, 1)));
      tmp.rsort();
      for (int j = 0; j < 16; j++) begin
        leaf_mem[k][j] = tmp[j];
        all_q.push_back(tmp[j]);
      end
      leaf_mem[k][16] = '0;
      leaf_len[k]     = 17;
      leaf_ptr[k]     = 0;
    end
    all_q.rsort();
    foreach (all_q[i]) exp_q.push_back(all_q[i]);
    exp_q.push_back('0);
    mask_leaf = 3;
    mask_from = cyc + 20;
    mask_to   = cyc + 70;
    run_until_drained("starve", 5000);
    mask_leaf = -1;

    // Case 6: reset mid-stream, then the tie case again
    load_big();
    repeat (40) tick();
    rst_n = 1'b0;
    exp_q.delete();
    clear_leaves();
    repeat (3) tick();
    rst_n = 1'b1;
    run_tie("tie_after_reset");

    chk("read_while_empty", 64'(rd_empty_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
